// File: rtl/key_debounce_irq_pkg.sv
// Shared constants for the push-button debounce / interrupt peripheral.
// Register word offsets and key count.
package key_debounce_irq_pkg;

  localparam int NKEYS = 8;

  localparam logic [2:0] KDI_STATE   = 3'd0;
  localparam logic [2:0] KDI_PENDING = 3'd1;
  localparam logic [2:0] KDI_MASK    = 3'd2;
  localparam logic [2:0] KDI_RAW     = 3'd3;

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchroniser, debounce counter and stable level.
// press_o pulses in the cycle whose closing edge accepts a press.
module key_debounce_cell #(
  parameter int DEB_CYCLES     = 250000,
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int CNT_W          = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic sync_o,
  output logic stable_o,
  output logic press_o
);

  localparam logic REL = KEY_ACTIVE_LOW;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q   <= REL;
      sync_q   <= REL;
      stable_q <= REL;
      cnt_q    <= '0;
    end else begin
      meta_q   <= key_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      stable_d = sync_q;
      cnt_d    = '0;
      accept   = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Only the transition into the pressed level is an event
  assign press_o  = accept & (sync_q ^ REL);
  assign sync_o   = sync_q;
  assign stable_o = stable_q;

endmodule

// File: rtl/key_debounce_irq.sv
// Debounced push-button peripheral: state, W1C pending and mask
// registers on the bridge read/write port, level irq on pending&mask.
module key_debounce_irq
  import key_debounce_irq_pkg::*;
#(
  parameter int DEB_CYCLES     = 250000,
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int CNT_W          = 20
) (
  input  logic             clk,
  input  logic             sys_rstn,
  input  logic [NKEYS-1:0] user_key,
  input  logic [2:0]       Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  output logic             irq
);

  logic [NKEYS-1:0] sync, stable, press, pressed;
  logic [NKEYS-1:0] pend_q, pend_d;
  logic [NKEYS-1:0] mask_q, mask_d;
  logic [NKEYS-1:0] w1c;
  logic             unused_din;

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_debounce_cell #(
      .DEB_CYCLES    (DEB_CYCLES),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW),
      .CNT_W         (CNT_W)
    ) u_cell (
      .clk_i   (clk),
      .rst_ni  (sys_rstn),
      .key_i   (user_key[i]),
      .sync_o  (sync[i]),
      .stable_o(stable[i]),
      .press_o (press[i])
    );
  end

  assign pressed    = stable ^ {NKEYS{KEY_ACTIVE_LOW}};
  assign unused_din = ^Din[31:NKEYS];

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  always_comb begin
    w1c    = '0;
    mask_d = mask_q;
    if (WE && Addr == KDI_PENDING) w1c = Din[NKEYS-1:0];
    if (WE && Addr == KDI_MASK) mask_d = Din[NKEYS-1:0];
    // A press arriving with its own clear keeps the bit set
    pend_d = (pend_q & ~w1c) | press;
  end

  always_comb begin
    Dout = '0;
    unique case (1'b1)
      Addr == KDI_STATE:   Dout[NKEYS-1:0] = pressed;
      Addr == KDI_PENDING: Dout[NKEYS-1:0] = pend_q;
      Addr == KDI_MASK:    Dout[NKEYS-1:0] = mask_q;
      Addr == KDI_RAW:     Dout[NKEYS-1:0] = sync;
      default:             Dout = '0;
    endcase
  end

  assign irq = |(pend_q & mask_q);

endmodule

// File: tb/tb_key_debounce_irq.sv
// Bench for key_debounce_irq: directed stimulus, expected reads queued
// and compared by a separate negedge monitor.
module tb_key_debounce_irq;

  logic        clk = 1'b0;
  logic        sys_rstn;
  logic [7:0]  user_key;
  logic [2:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        irq;
  logic        rd_vld;

  typedef struct {
    string       name;
    logic [31:0] dout;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  key_debounce_irq #(
    .DEB_CYCLES    (4),
    .KEY_ACTIVE_LOW(1'b1),
    .CNT_W         (20)
  ) dut (
    .clk     (clk),
    .sys_rstn(sys_rstn),
    .user_key(user_key),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        n_tot++;
        $display("FAIL monitor: read with no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, ".dout"}, Dout, e.dout);
        chk({e.name, ".irq"}, {31'b0, irq}, {31'b0, e.irq});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input string nm, input logic [2:0] a,
                    input logic [7:0] d, input logic i);
    exp_t e;
    e.name = nm;
    e.dout = {24'b0, d};
    e.irq  = i;
    exp_q.push_back(e);
    Addr   = a;
    rd_vld = 1'b1;
    @(posedge clk);
    #1;
    rd_vld = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    Addr = a;
    Din  = {24'hA5A5A5, d};
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE   = 1'b0;
    Din  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rstn = 1'b0;
    user_key = 8'hFF;
    Addr     = 3'd0;
    WE       = 1'b0;
    Din      = '0;
    rd_vld   = 1'b0;
    cyc(3);
    sys_rstn = 1'b1;
    cyc(20);
    rd("rst_state", 3'd0, 8'h00, 1'b0);
    rd("rst_pend",  3'd1, 8'h00, 1'b0);
    rd("rst_mask",  3'd2, 8'h00, 1'b0);
    rd("rst_raw",   3'd3, 8'hFF, 1'b0);

    // key 0 press: stable flips at the 6th edge
    user_key = 8'hFE;
    cyc(5);
    rd("k0_early", 3'd0, 8'h00, 1'b0);
    rd("k0_state", 3'd0, 8'h01, 1'b0);
    rd("k0_pend",  3'd1, 8'h01, 1'b0);
    rd("k0_raw",   3'd3, 8'hFE, 1'b0);
    wr(3'd2, 8'h01);
    rd("k0_mask",  3'd2, 8'h01, 1'b1);

    // two back-to-back 3-cycle glitches on key 3
    for (int g = 0; g < 2; g++) begin
      user_key = 8'hF6;
      cyc(2);
      rd("gl_raw0", 3'd3, 8'hF6, 1'b1);
      user_key = 8'hFE;
      rd("gl_raw1", 3'd3, 8'hF6, 1'b1);
      rd("gl_raw2", 3'd3, 8'hF6, 1'b1);
      rd("gl_raw3", 3'd3, 8'hFE, 1'b1);
      cyc(1);
    end
    cyc(10);
    rd("gl_state", 3'd0, 8'h01, 1'b1);
    rd("gl_pend",  3'd1, 8'h01, 1'b1);

    // W1C clears and drops irq
    wr(3'd1, 8'h01);
    rd("w1c_pend", 3'd1, 8'h00, 1'b0);
    user_key = 8'hFF;
    cyc(10);
    rd("rel_state", 3'd0, 8'h00, 1'b0);
    rd("rel_pend",  3'd1, 8'h00, 1'b0);

    // re-press with W1C on the accepting edge: set wins
    user_key = 8'hFE;
    cyc(5);
    wr(3'd1, 8'h01);
    rd("race_pend",  3'd1, 8'h01, 1'b1);
    rd("race_state", 3'd0, 8'h01, 1'b1);
    wr(3'd1, 8'h01);
    rd("race_clr",   3'd1, 8'h00, 1'b0);

    // keys 2 and 5 together
    user_key = 8'hDA;
    cyc(8);
    wr(3'd2, 8'h20);
    rd("k25_pend",  3'd1, 8'h24, 1'b1);
    rd("k25_state", 3'd0, 8'h25, 1'b1);
    wr(3'd2, 8'h00);
    rd("k25_mask0", 3'd1, 8'h24, 1'b0);
    wr(3'd1, 8'h04);
    rd("k25_part",  3'd1, 8'h20, 1'b0);
    wr(3'd0, 8'hFF);
    wr(3'd3, 8'h00);
    wr(3'd6, 8'hFF);
    rd("ro_state",  3'd0, 8'h25, 1'b0);
    rd("ro_raw",    3'd3, 8'hDA, 1'b0);
    rd("ro_mask",   3'd2, 8'h00, 1'b0);
    rd("hole5",     3'd5, 8'h00, 1'b0);
    wr(3'd2, 8'h20);
    rd("rearm",     3'd1, 8'h20, 1'b1);

    // key 7 mid-count, then asynchronous reset
    user_key = 8'h5A;
    cyc(3);
    #2;
    sys_rstn = 1'b0;
    rd("ar_state", 3'd0, 8'h00, 1'b0);
    rd("ar_pend",  3'd1, 8'h00, 1'b0);
    rd("ar_mask",  3'd2, 8'h00, 1'b0);
    rd("ar_raw",   3'd3, 8'hFF, 1'b0);
    user_key = 8'hFF;
    cyc(2);
    sys_rstn = 1'b1;
    cyc(10);
    rd("post_pend",  3'd1, 8'h00, 1'b0);
    rd("post_state", 3'd0, 8'h00, 1'b0);

    cyc(2);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/key_debounce_irq.md
Name: key_debounce_irq

Overview:
- Memory-mapped input peripheral directly upstream of the bridge, in the same bus slot as the key device.
- Synchronises and debounces the 8 raw board push-buttons (user_key).
- Latches press events into pending bits and raises a level interrupt into HWInt[4] (the keys interrupt line).
- Presents debounced state, pending and mask registers to the CPU on the bridge's word-addressed read/write interface.

Parameters:
- DEB_CYCLES, 250000, consecutive clk cycles a synchronised key level must differ from the stable level before it is accepted (10 ms at 25 MHz); legal range 2..2^20-1.
- KEY_ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed; 0 = reads 1 when pressed.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk  input  1  system clock (clk1 domain); all state updates on its rising edge.
- sys_rstn  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- user_key  input  8  raw, asynchronous, bouncing key levels from the board pins.
- Addr  input  3  word address bits [4:2] from the bridge.
- WE  input  1  write strobe for the selected register; sampled on the rising clk edge.
- Din  input  32  write data from the bridge.
- Dout  output  32  combinational read data for Addr.
- irq  output  1  level interrupt = |(pending & mask).

Behaviour:
- Reset (sys_rstn=0, asynchronous):
  - Both synchroniser stages, stable[7:0] and the raw mirror are forced to the released level (all 1 when KEY_ACTIVE_LOW=1, else all 0).
  - All debounce counters = 0; pending = 0; mask = 0; irq = 0.
  - Releasing reset while a key is held produces no press event until the debounce time has elapsed.
- Synchroniser: 2-flop chain per key; sync[i] reflects user_key[i] 2 cycles after it changes.
- Per-key debounce, one cell per key, evaluated every cycle:
  - If sync == stable: counter <= 0.
  - Else if counter == DEB_CYCLES-1: stable <= sync, counter <= 0.
  - Else: counter <= counter+1.
  - A glitch shorter than DEB_CYCLES cycles never changes stable.
  - Latency: a clean edge on user_key at cycle t updates stable at the edge ending cycle t+2+DEB_CYCLES.
- Press detect: pressed[i] = stable[i] XOR KEY_ACTIVE_LOW.
  - A 0->1 transition of pressed[i] sets pending[i] in the same cycle that stable updates.
  - Release does not set pending.
- Register map (Addr):
  - 0: STATE, read-only, {24'b0, pressed}.
  - 1: PENDING, read, or write-1-to-clear using Din[7:0].
  - 2: MASK, read/write, Din[7:0].
  - 3: RAW, read-only, {24'b0, sync}, for diagnostics.
  - 4-7: read 0, writes ignored.
- Simultaneous events:
  - A W1C of pending[i] in the same cycle as a new press event on key i leaves pending[i]=1 (set wins).
  - Writes to other bits are unaffected.
- irq is combinational from the pending and mask registers.
  - It rises the cycle after pending/mask is updated.
  - It stays high until the CPU clears every masked pending bit or masks them.
- Writing MASK while pending is set immediately raises or drops irq; masking never clears pending.
- Dout upper 24 bits are always 0.
- A write with Addr=0 or 3 has no effect.

Decomposition:
- Shared package: register offset constants (KDI_STATE=0, KDI_PENDING=1, KDI_MASK=2, KDI_RAW=3) and the key-count constant (8).
- Sub-module key_debounce_cell (one instance per key):
  - Holds the 2-flop synchroniser, CNT_W counter and stable flop.
  - Outputs stable and a one-cycle press pulse.
- The top level holds pending, mask, the read mux and irq.

Test Plan (DEB_CYCLES=4, KEY_ACTIVE_LOW=1):
- Reset with user_key=8'hFF, release sys_rstn, hold 20 cycles -> STATE=0, PENDING=0, RAW=8'hFF, irq=0.
- Drive user_key[0]=0 at cycle t and hold -> STATE reads 8'h01 from cycle t+6; PENDING=8'h01; irq stays 0 until MASK is written 8'h01, then irq=1 on the next cycle.
- Pulse user_key[3]=0 for 3 cycles, then 1 -> STATE, PENDING and the key-3 counter return to 0; RAW shows the 3-cycle pulse delayed by 2 cycles.
- With PENDING=8'h01 and MASK=8'h01, write PENDING=8'h01 -> PENDING=0 and irq drops the next cycle.
  - Repeat with key 0 re-pressed so its stable update coincides with the W1C cycle -> PENDING remains 8'h01 and irq stays 1.
- Press keys 2 and 5 together, MASK=8'h20 -> PENDING=8'h24, irq=1.
  - Write MASK=8'h00 -> irq=0 while PENDING stays 8'h24.
- Hold user_key[7]=0 for 3 cycles, then assert sys_rstn=0 asynchronously mid-count -> all registers read reset values immediately, irq=0; after release no spurious pending bit.
